// File: rtl/rx_samp_pkg.sv
// Package rx_samp_pkg: shared types, constants and helpers for the UART RX oversampling voter.
//   samp_state_e      - capture FSM state (StIdle / StCollect / StDone)
//   MAX_SAMPLES       - largest supported sample count
//   K                 - half-window of the default 3-sample configuration
//   popcount_gt_half  - majority of the low n bits of a MAX_SAMPLES-wide vector
package rx_samp_pkg;

  localparam int unsigned MAX_SAMPLES     = 7;
  localparam int unsigned DEF_NUM_SAMPLES = 3;
  localparam int unsigned K               = (DEF_NUM_SAMPLES - 1) / 2;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDone
  } samp_state_e;

  function automatic logic popcount_gt_half(input logic [MAX_SAMPLES-1:0] s,
                                            input int unsigned n);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MAX_SAMPLES; i++) begin
      if (i < n && s[i]) cnt++;
    end
    return cnt > (n - 1) / 2;
  endfunction

endpackage

// File: rtl/rx_oversample_voter_if.sv
// Interface rx_oversample_voter_if: sampling handshake between the RX bit counter and the voter.
//   data_samp_en, edge_cnt, RX_IN, prescale  - driven by the master (RX FSM side)
//   sampled_bit, sample_valid, cfg_err       - driven by the slave (voter)
//   noise_flag                               - slave output, present only with RX_SAMP_NOISE_FLAG_EN
interface rx_oversample_voter_if #(
  parameter int unsigned PRESCALE_W = 6
);
  logic                  data_samp_en;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] prescale;
  logic                  sampled_bit;
  logic                  sample_valid;
  logic                  cfg_err;
`ifdef RX_SAMP_NOISE_FLAG_EN
  logic                  noise_flag;

  modport master (
    output data_samp_en, edge_cnt, RX_IN, prescale,
    input  sampled_bit, sample_valid, cfg_err, noise_flag
  );
  modport slave (
    input  data_samp_en, edge_cnt, RX_IN, prescale,
    output sampled_bit, sample_valid, cfg_err, noise_flag
  );
`else
  modport master (
    output data_samp_en, edge_cnt, RX_IN, prescale,
    input  sampled_bit, sample_valid, cfg_err
  );
  modport slave (
    input  data_samp_en, edge_cnt, RX_IN, prescale,
    output sampled_bit, sample_valid, cfg_err
  );
`endif
endinterface

// File: rtl/rx_majority_vote.sv
// rx_majority_vote: combinational majority of NUM_SAMPLES captured bits.
//   samples    in   captured RX samples
//   vote       out  1 when more than half of the samples are 1
//   all_equal  out  all samples identical (only with RX_SAMP_NOISE_FLAG_EN)
module rx_majority_vote
  import rx_samp_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 3
) (
  input  logic [NUM_SAMPLES-1:0] samples,
  output logic                   vote
`ifdef RX_SAMP_NOISE_FLAG_EN
  ,
  output logic                   all_equal
`endif
);

  logic [MAX_SAMPLES-1:0] padded;

  always_comb begin
    padded = '0;
    padded[NUM_SAMPLES-1:0] = samples;
  end

  assign vote = popcount_gt_half(padded, NUM_SAMPLES);

`ifdef RX_SAMP_NOISE_FLAG_EN
  assign all_equal = (samples == '0) || (samples == '1);
`endif

endmodule

// File: rtl/rx_oversample_voter.sv
// rx_oversample_voter: captures NUM_SAMPLES copies of RX_IN centred on mid-bit, majority-votes
// them and emits a registered bit with a one-cycle valid strobe.
//   clk    in  clock
//   ARSTn  in  asynchronous active-low reset
//   bus    rx_oversample_voter_if.slave (data_samp_en, edge_cnt, RX_IN, prescale in;
//          sampled_bit, sample_valid, cfg_err, [noise_flag] out)
// Optional feature macro: RX_SAMP_NOISE_FLAG_EN adds the registered noise_flag output.
module rx_oversample_voter
  import rx_samp_pkg::*;
#(
  parameter int unsigned PRESCALE_W  = 6,
  parameter int unsigned NUM_SAMPLES = 2 * K + 1
) (
  input logic                       clk,
  input logic                       ARSTn,
  rx_oversample_voter_if.slave      bus
);

  localparam int unsigned SAMP_K       = (NUM_SAMPLES - 1) / 2;
  // One extra bit so window indices past the prescale range never alias a real edge_cnt.
  localparam int unsigned IDX_W        = PRESCALE_W + 1;
  localparam int unsigned MIN_PRESCALE = (NUM_SAMPLES + 1 > 4) ? NUM_SAMPLES + 1 : 4;
  localparam logic [IDX_W-1:0] K_IDX   = IDX_W'(SAMP_K);

  samp_state_e            state_q, state_d;
  logic [NUM_SAMPLES-1:0] samples_q, samples_d;
  logic [NUM_SAMPLES-1:0] mask_q, mask_d;
  logic                   bit_q, bit_d;
  logic                   valid_q, valid_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   vote;
  logic [IDX_W-1:0]       half_idx, first_idx;
  logic [NUM_SAMPLES-1:0] hit;
`ifdef RX_SAMP_NOISE_FLAG_EN
  logic                   noise_q, noise_d;
  logic                   all_equal;
`endif

  rx_majority_vote #(
    .NUM_SAMPLES (NUM_SAMPLES)
  ) u_vote (
    .samples   (samples_q),
`ifdef RX_SAMP_NOISE_FLAG_EN
    .all_equal (all_equal),
`endif
    .vote      (vote)
  );

  // center = half - 1; first = center - K, clamped at 0 (checked as half <= K to avoid underflow).
  always_comb begin
    half_idx  = {2'b00, bus.prescale[PRESCALE_W-1:1]};
    first_idx = (half_idx <= K_IDX) ? '0 : half_idx - K_IDX - IDX_W'(1);
    hit       = '0;
    for (int unsigned i = 0; i < NUM_SAMPLES; i++) begin
      hit[i] = ({1'b0, bus.edge_cnt} == first_idx + IDX_W'(i));
    end
  end

  assign cfg_err_d = bus.prescale[0] | (bus.prescale < PRESCALE_W'(MIN_PRESCALE));

  always_comb begin
    state_d   = state_q;
    samples_d = samples_q;
    mask_d    = mask_q;
    bit_d     = bit_q;
    valid_d   = 1'b0;
`ifdef RX_SAMP_NOISE_FLAG_EN
    noise_d   = noise_q;
`endif
    if (!bus.data_samp_en) begin
      state_d   = StIdle;
      samples_d = '0;
      mask_d    = '0;
`ifdef RX_SAMP_NOISE_FLAG_EN
      noise_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: state_d = StCollect;
        StCollect: begin
          if (&mask_q) begin
            bit_d     = vote;
            valid_d   = 1'b1;
`ifdef RX_SAMP_NOISE_FLAG_EN
            noise_d   = ~all_equal;
`endif
            samples_d = '0;
            mask_d    = '0;
            // A window ending on the last edge lands the vote on the next bit's edge 0.
            state_d   = (bus.edge_cnt == '0) ? StCollect : StDone;
          end else if (bus.edge_cnt == '0) begin
            // Bit boundary with an incomplete window: drop partial samples and restart.
            samples_d = '0;
            mask_d    = '0;
          end
          if (!(&mask_q) || bus.edge_cnt == '0) begin
            for (int unsigned i = 0; i < NUM_SAMPLES; i++) begin
              if (hit[i]) begin
                samples_d[i] = bus.RX_IN;
                mask_d[i]    = 1'b1;
              end
            end
          end
        end
        StDone: begin
          if (bus.edge_cnt == '0) begin
            samples_d = '0;
            mask_d    = '0;
            state_d   = StCollect;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q   <= StIdle;
      samples_q <= '0;
      mask_q    <= '0;
      bit_q     <= 1'b0;
      valid_q   <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef RX_SAMP_NOISE_FLAG_EN
      noise_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      samples_q <= samples_d;
      mask_q    <= mask_d;
      bit_q     <= bit_d;
      valid_q   <= valid_d;
      cfg_err_q <= cfg_err_d;
`ifdef RX_SAMP_NOISE_FLAG_EN
      noise_q   <= noise_d;
`endif
    end
  end

  assign bus.sampled_bit  = bit_q;
  assign bus.sample_valid = valid_q;
  assign bus.cfg_err      = cfg_err_q;
`ifdef RX_SAMP_NOISE_FLAG_EN
  assign bus.noise_flag   = noise_q;
`endif

endmodule

// File: tb/tb_rx_oversample_voter.sv
// Scoreboard bench for rx_oversample_voter: a 3-sample and a 5-sample instance see identical
// stimulus; expected votes (value, noise, pulse cycle) are queued when each bit is issued and
// popped by per-instance monitors whenever sample_valid is seen.
module tb_rx_oversample_voter;

  localparam int unsigned PW = 6;

  typedef struct {
    logic b;
    logic noise;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic ARSTn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q3[$];
  exp_t q5[$];
  exp_t e3, e5;
  logic last3, last5;
  logic rx_pat[0:63];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rx_oversample_voter_if #(.PRESCALE_W(PW)) bus3 ();
  rx_oversample_voter_if #(.PRESCALE_W(PW)) bus5 ();

  rx_oversample_voter #(.PRESCALE_W(PW), .NUM_SAMPLES(3)) dut3 (
    .clk   (clk),
    .ARSTn (ARSTn),
    .bus   (bus3)
  );
  rx_oversample_voter #(.PRESCALE_W(PW), .NUM_SAMPLES(5)) dut5 (
    .clk   (clk),
    .ARSTn (ARSTn),
    .bus   (bus5)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic en, input int ec, input logic rx, input int p);
    bus3.data_samp_en = en;  bus5.data_samp_en = en;
    bus3.edge_cnt = PW'(ec); bus5.edge_cnt = PW'(ec);
    bus3.RX_IN = rx;         bus5.RX_IN = rx;
    bus3.prescale = PW'(p);  bus5.prescale = PW'(p);
  endtask

  // Reference: window from the centring rule, vote = majority of scheduled samples.
  task automatic predict(input int n, input int p, input int base, input bit fresh);
    int half, k, first, last, ones;
    exp_t e;
    half = p / 2;
    k = (n - 1) / 2;
    first = (half - 1 < k) ? 0 : half - 1 - k;
    last = first + n - 1;
    if (last > p - 1) return;        // window never completes
    if (first == 0 && !fresh) return; // edge 0 arrives while still in DONE
    ones = 0;
    for (int i = first; i <= last; i++) ones += int'(rx_pat[i]);
    e.b = (ones > k);
    e.noise = (ones != 0) && (ones != n);
    e.cyc = base + last + 2;
    if (n == 3) begin q3.push_back(e); last3 = e.b; end
    else begin q5.push_back(e); last5 = e.b; end
  endtask

  task automatic chk_cfg(input int p);
    chk("cfg_err_n3", int'(bus3.cfg_err), int'((p % 2 == 1) || p < 4));
    chk("cfg_err_n5", int'(bus5.cfg_err), int'((p % 2 == 1) || p < 6));
  endtask

  // Drop enable for a cycle, then one enabled cycle to enter collection before edge 0.
  task automatic arm(input int p);
    set_in(1'b0, 0, 1'b0, p);
    tick();
    set_in(1'b1, p - 1, 1'b0, p);
    tick();
  endtask

  task automatic run_frame(input int p, input bit fresh, input int abort_at, input int rst_at);
    int base;
    base = cyc;
    if (abort_at < 0 && rst_at < 0) begin
      predict(3, p, base, fresh);
      predict(5, p, base, fresh);
    end
    for (int j = 0; j < p; j++) begin
      if (j == rst_at) begin
        ARSTn = 1'b0;
        #1;
        chk("rst_bit_n3", int'(bus3.sampled_bit), 0);
        chk("rst_bit_n5", int'(bus5.sampled_bit), 0);
        chk("rst_valid_n3", int'(bus3.sample_valid), 0);
        chk("rst_cfg_n5", int'(bus5.cfg_err), 0);
`ifdef RX_SAMP_NOISE_FLAG_EN
        chk("rst_noise_n3", int'(bus3.noise_flag), 0);
`endif
        last3 = 1'b0;
        last5 = 1'b0;
        @(posedge clk);
        #1;
        ARSTn = 1'b1;
        return;
      end
      set_in((abort_at < 0) || (j < abort_at), j, rx_pat[j], p);
      tick();
    end
  endtask

  task automatic rand_pat();
    for (int i = 0; i < 64; i++) rx_pat[i] = 1'($urandom_range(0, 1));
  endtask

  always @(negedge clk) begin
    if (ARSTn && bus3.sample_valid) begin
      if (q3.size() == 0) chk("n3_unexpected_pulse", 1, 0);
      else begin
        e3 = q3.pop_front();
        chk("n3_bit", int'(bus3.sampled_bit), int'(e3.b));
        chk("n3_pulse_cycle", cyc, e3.cyc);
`ifdef RX_SAMP_NOISE_FLAG_EN
        chk("n3_noise", int'(bus3.noise_flag), int'(e3.noise));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (ARSTn && bus5.sample_valid) begin
      if (q5.size() == 0) chk("n5_unexpected_pulse", 1, 0);
      else begin
        e5 = q5.pop_front();
        chk("n5_bit", int'(bus5.sampled_bit), int'(e5.b));
        chk("n5_pulse_cycle", cyc, e5.cyc);
`ifdef RX_SAMP_NOISE_FLAG_EN
        chk("n5_noise", int'(bus5.noise_flag), int'(e5.noise));
`endif
      end
    end
  end

  initial begin
    int p;
    ARSTn = 1'b0;
    last3 = 1'b0;
    last5 = 1'b0;
    set_in(1'b0, 0, 1'b0, 8);
    tick();
    tick();
    chk("reset_bit_n3", int'(bus3.sampled_bit), 0);
    chk("reset_valid_n3", int'(bus3.sample_valid), 0);
    chk("reset_cfg_n3", int'(bus3.cfg_err), 0);
    chk("reset_bit_n5", int'(bus5.sampled_bit), 0);
    chk("reset_valid_n5", int'(bus5.sample_valid), 0);
`ifdef RX_SAMP_NOISE_FLAG_EN
    chk("reset_noise_n5", int'(bus5.noise_flag), 0);
`endif
    ARSTn = 1'b1;
    tick();

    // 1: prescale 8, N=3 window 2..4 sees 1,0,1
    arm(8);
    chk_cfg(8);
    rand_pat();
    rx_pat[2] = 1'b1; rx_pat[3] = 1'b0; rx_pat[4] = 1'b1;
    run_frame(8, 1'b1, -1, -1);

    // 2: prescale 16, N=5 window 5..9 sees 0,0,1,0,0 over four consecutive bits
    arm(16);
    for (int f = 0; f < 4; f++) begin
      rand_pat();
      rx_pat[5] = 1'b0; rx_pat[6] = 1'b0; rx_pat[7] = 1'b1; rx_pat[8] = 1'b0; rx_pat[9] = 1'b0;
      run_frame(16, f == 0, -1, -1);
    end
    chk_cfg(16);

    // 3: enable dropped at edge 3 -> no pulse, sampled_bit holds
    arm(8);
    rand_pat();
    run_frame(8, 1'b1, 3, -1);
    tick();
    chk("hold_bit_n3", int'(bus3.sampled_bit), int'(last3));
    chk("hold_bit_n5", int'(bus5.sampled_bit), int'(last5));

    // 4: prescale 4 (N=5 window unreachable) and odd prescale 7
    arm(4);
    chk_cfg(4);
    rand_pat();
    run_frame(4, 1'b1, -1, -1);
    arm(7);
    chk_cfg(7);
    rand_pat();
    run_frame(7, 1'b1, -1, -1);

    // 5: prescale 32, reset mid-window after a 1 has been voted
    arm(32);
    for (int i = 0; i < 64; i++) rx_pat[i] = 1'b1;
    run_frame(32, 1'b1, -1, -1);
    rand_pat();
    run_frame(32, 1'b0, -1, 15);
    arm(32);
    rand_pat();
    run_frame(32, 1'b1, -1, -1);
    chk_cfg(32);

    // 6: random prescale and RX_IN
    for (int g = 0; g < 10; g++) begin
      p = int'($urandom_range(8, 40));
      arm(p);
      for (int f = 0; f < 4; f++) begin
        rand_pat();
        run_frame(p, f == 0, -1, -1);
      end
      chk_cfg(p);
    end

    set_in(1'b0, 0, 1'b0, 8);
    repeat (3) tick();
    chk("n3_queue_drained", q3.size(), 0);
    chk("n5_queue_drained", q5.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
